// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining UART transmitter
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // frame_done is registered, so it is raised one cycle before the last stop cycle
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic          ODD       = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q;
  logic [BW-1:0]    baud_q;
  logic [CW-1:0]    bit_q;
  logic             stop_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             parity_q;
  logic             tx_q;
  logic             rd_q;
  logic             busy_q;
  logic             done_q;
  logic             baud_last;

  // Next shift-register value at a data bit boundary and end-of-bit flag
  always_comb begin
    shift_d   = shift_q >> 1;
    baud_last = (baud_q == BAUD_LAST);
  end

  // Transmit FSM: every output is updated here so none has a combinational input path
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (en && !fifo_empty) begin
            state_q <= FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q  <= fifo_data;
          parity_q <= (^fifo_data) ^ ODD;
          tx_q     <= 1'b0;
          baud_q   <= '0;
          state_q  <= START;
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
                state_q <= STOP;
              end
            end else begin
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (stop_q == STOP_LAST && baud_q == BAUD_PRE) begin
            done_q <= 1'b1;
          end
          if (baud_last) begin
            baud_q <= '0;
            if (stop_q == STOP_LAST) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd    = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
